// File: rtl/write_back_pkg.sv
// Shared widths, wselector bit positions and PC helper for the write-back stage.
package write_back_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;
  localparam int unsigned WSEL_W     = 3;

  localparam int unsigned WS_PC    = 2;
  localparam int unsigned WS_REG   = 1;
  localparam int unsigned WS_FLOAT = 0;

  // Branch targets are forced to word alignment.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/write_back_if.sv
// Execute/decode/fetch-facing signal bundle of the write-back stage.
interface write_back_if;
  import write_back_pkg::*;

  logic                  done;
  logic [WSEL_W-1:0]     wselector;
  logic [XLEN-1:0]       data;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       pc_in;
  logic                  stall_enable;
  logic [REG_ADDR_W-1:0] rs_no;
  logic [REG_ADDR_W-1:0] rt_no;
  logic                  fmode;
  logic [XLEN-1:0]       rs_data;
  logic [XLEN-1:0]       rt_data;
  logic                  fetch_enable;
  logic [XLEN-1:0]       fetch_pc;
  logic [XLEN-1:0]       instret;

  modport master (
    output done, wselector, data, rd, pc_in, stall_enable, rs_no, rt_no, fmode,
    input  rs_data, rt_data, fetch_enable, fetch_pc, instret
  );

  modport slave (
    input  done, wselector, data, rd, pc_in, stall_enable, rs_no, rt_no, fmode,
    output rs_data, rt_data, fetch_enable, fetch_pc, instret
  );

endinterface

// File: rtl/write_back_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// asynchronous clear.
module reg_file
  import write_back_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [XLEN-1:0]       rdata_a,
  output logic [XLEN-1:0]       rdata_b
);

  logic [XLEN-1:0] mem_q [NUM_REGS];
  logic [XLEN-1:0] mem_d [NUM_REGS];

  always_comb begin
    // NOTE: copy every entry first so the conditional write cannot infer a latch.
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage itself is cleared on reset because reads must return 0
      // afterwards; this keeps the array in flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/write_back.sv
// Write-back and PC-sequencing stage: commits execute results, sequences the
// next fetch PC, counts retired instructions and serves decode reads with bypass.
module write_back
  import write_back_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  write_back_if.slave wb
);

  logic            boot_q,     boot_d;
  logic            fetch_en_q, fetch_en_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] instret_q,  instret_d;

  logic            commit;
  logic            reg_we;
  logic            int_we;
  logic            fp_we;
  logic [XLEN-1:0] int_rs, int_rt, fp_rs, fp_rt;
  logic            unused_pc_low;

  // The boot cycle swallows done, so nothing commits or bypasses in it.
  assign commit = wb.done && !boot_q && !wb.stall_enable;
  assign reg_we = commit && wb.wselector[WS_REG] && (wb.rd != '0);
  assign int_we = reg_we && !wb.wselector[WS_FLOAT];
  assign fp_we  = reg_we &&  wb.wselector[WS_FLOAT];
  assign unused_pc_low = ^wb.pc_in[1:0];

  reg_file u_int_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (int_we),
    .waddr   (wb.rd),
    .wdata   (wb.data),
    .raddr_a (wb.rs_no),
    .raddr_b (wb.rt_no),
    .rdata_a (int_rs),
    .rdata_b (int_rt)
  );

  reg_file u_fp_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (fp_we),
    .waddr   (wb.rd),
    .wdata   (wb.data),
    .raddr_a (wb.rs_no),
    .raddr_b (wb.rt_no),
    .rdata_a (fp_rs),
    .rdata_b (fp_rt)
  );

  function automatic logic [XLEN-1:0] read_port(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       int_val,
    input logic [XLEN-1:0]       fp_val
  );
    if (addr == '0) return '0;
    if (reg_we && (wb.wselector[WS_FLOAT] == wb.fmode) && (addr == wb.rd)) return wb.data;
    return wb.fmode ? fp_val : int_val;
  endfunction

  assign wb.rs_data = read_port(wb.rs_no, int_rs, fp_rs);
  assign wb.rt_data = read_port(wb.rt_no, int_rt, fp_rt);

  always_comb begin
    boot_d     = 1'b0;
    fetch_en_d = 1'b0;
    fetch_pc_d = fetch_pc_q;
    instret_d  = instret_q;
    if (boot_q) begin
      fetch_en_d = 1'b1;
      fetch_pc_d = RESET_PC;
    end else if (wb.done) begin
      fetch_en_d = 1'b1;
      if (wb.stall_enable) begin
        fetch_pc_d = align_pc(wb.pc_in);
      end else begin
        fetch_pc_d = wb.wselector[WS_PC] ? align_pc(wb.pc_in) : fetch_pc_q + 32'd4;
        instret_d  = instret_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_q     <= 1'b1;
      fetch_en_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      instret_q  <= '0;
    end else begin
      boot_q     <= boot_d;
      fetch_en_q <= fetch_en_d;
      fetch_pc_q <= fetch_pc_d;
      instret_q  <= instret_d;
    end
  end

  assign wb.fetch_enable = fetch_en_q;
  assign wb.fetch_pc     = fetch_pc_q;
  assign wb.instret      = instret_q;

endmodule

// File: doc/write_back.md
# write_back

Write-back and PC-sequencing stage that sits directly downstream of the execute stage. On every execute completion pulse it commits the result to the integer or float register file and selects the next PC. It then issues a one-cycle fetch request for that PC. It also serves the decode stage's combinational register reads, with write-through bypass.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- clk  in  1: clock, all state on rising edge.
- rst  in  1: asynchronous, active-high reset.
- done  in  1: execute completion pulse, one cycle per instruction.
- wselector  in  3: bit2 = PC write, bit1 = register write, bit0 = float file (1) / integer file (0).
- data  in  32: result to write.
- rd  in  5: destination register number.
- pc_in  in  32: branch/jump target, valid when wselector[2] or stall_enable.
- stall_enable  in  1: execute discarded the instruction (wrong-path), qualified by done.
- rs_no, rt_no  in  5 each: decode read addresses.
- fmode  in  1: decode reads the float file when 1.
- rs_data, rt_data  out  32 each: read data, combinational.
- fetch_enable  out  1: one-cycle fetch request.
- fetch_pc  out  32: address for fetch, held between requests.
- instret  out  32: retired-instruction counter.

## Operation
- Reset (async, rst=1): both register files cleared to 0, fetch_pc=RESET_PC, fetch_enable=0, instret=0, boot flag=1.
- Boot: in the first clock after rst deasserts, fetch_enable=1 with fetch_pc=RESET_PC, and the boot flag clears. done is ignored in that cycle.
- On done=1 and stall_enable=0:
  - Register write when wselector[1]=1 and rd!=0, to the file selected by wselector[0]. Register 0 of both files reads zero and ignores writes.
  - PC update: fetch_pc <= wselector[2] ? {pc_in[31:2],2'b00} : fetch_pc+4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - instret <= instret+1, modulo 2^32.
  - fetch_enable=1 on the next cycle.
- On done=1 and stall_enable=1:
  - No register write and no instret increment.
  - fetch_pc <= {pc_in[31:2],2'b00}.
  - fetch_enable=1 on the next cycle.
- done=0: no state change, fetch_enable=0.
- Reads:
  - rs_data = (rs_no==0) ? 0 : file[fmode][rs_no]. rt_data follows the same rule with rt_no.
  - Write-through bypass: if done and the write is valid for the same file and register number in the current cycle, the read returns data.
- wselector=3'b000 with done: PC advances by 4, instret increments, no register write.

## Timing
- Register write is visible on the read ports combinationally in the done cycle (via bypass) and from storage in every later cycle.
- fetch_enable is asserted exactly 1 cycle after done and lasts 1 cycle. fetch_pc is updated in that same cycle and stays stable until the next done.
- done is never asserted on two consecutive cycles by execute. If it is, each pulse is processed independently with no loss.
- rst asserted mid-operation aborts a pending fetch_enable immediately. The boot sequence restarts after release.

## Structure
- Package write_back_pkg holds:
  - wselector bit positions: WS_PC=2, WS_REG=1, WS_FLOAT=0.
  - Width constants: XLEN=32, REG_ADDR_W=5.
- Sub-module reg_file: 32x32, two combinational read ports, one synchronous write port, async clear. It is instantiated twice (integer and float).
- write_back contains the read-port mux, bypass, PC sequencer, boot flag and instret counter.

## Test plan
- Reset release -> one cycle later fetch_enable=1, fetch_pc=0. instret=0 and all reads return 0.
- done, wselector=3'b010, rd=5, data=32'h1234_5678 -> rs_no=5, fmode=0 returns 32'h1234_5678 in the same cycle. fmode=1 returns 0. fetch_pc=+4, instret=1.
- done, wselector=3'b011, rd=0, data=32'hDEAD_BEEF -> f0 still reads 0. Float write to rd=3 reads back only with fmode=1.
- done, wselector=3'b110, rd=31, data=32'h0000_0104, pc_in=32'h0000_0203 -> r31=32'h104, fetch_pc=32'h200, fetch_enable pulse next cycle.
- done with stall_enable=1, wselector=3'b000, pc_in=32'h400 -> no register change, instret unchanged, fetch_pc=32'h400.
- fetch_pc=32'hFFFF_FFFC, done with wselector=3'b010 -> fetch_pc=0. rst pulsed mid-run -> registers cleared, boot fetch at RESET_PC.
